// File: rtl/arbiter_n_to_1_pkg.sv
// Shared definitions for the N-to-1 stream arbiter.
//   clog2        : ceiling log2 usable in parameter expressions
//   source_width : width of a channel index (never less than 1 bit)
//   lock_state_e : packet-lock state of the grant logic
package arbiter_n_to_1_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int source_width(input int num_inputs);
    return (num_inputs > 1) ? clog2(num_inputs) : 1;
  endfunction

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/arbiter_n_to_1_skid_register.sv
// skid_register: registered valid/ready stage with one skid entry.
// The upstream ready depends only on local state (skid empty), never on
// out_ready, so it cuts the ready timing path while still moving one word
// per cycle.
//   clock, reset_n : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready    : upstream stream
//   out_data/out_valid/out_ready : downstream stream (registered)
module skid_register #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             push;

  assign in_ready = !skid_valid;
  assign push     = in_valid && in_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (skid_valid && out_ready) begin
        // The older skid word goes first; push is impossible while skid is full.
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (push && (!out_valid || out_ready)) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else if (push) begin
        // Output is stalled: park the new word, output holds.
        skid_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // NOTE: the skid payload is qualified by skid_valid, so it carries no reset;
  // only control state needs a defined value after reset.
  always_ff @(posedge clock) begin
    if (push && out_valid && !out_ready) skid_data <= in_data;
  end

endmodule

// File: rtl/arbiter_n_to_1.sv
// arbiter_n_to_1: N-input valid/ready stream arbiter feeding one registered
// output. Rotating or fixed priority, optional packet lock that keeps the
// grant on one channel until its in_last beat is accepted.
//   clock, reset_n : clock, asynchronous active-low reset
//   in_data   : channel i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_last   : per-channel end-of-packet flag
//   in_valid  : per-channel valid
//   in_ready  : per-channel ready, at most one bit set
//   out_data, out_last, out_source, out_valid : registered output beat
//   out_ready : sink ready
module arbiter_n_to_1
  import arbiter_n_to_1_pkg::*;
#(
  parameter int  NUM_INPUTS   = 4,
  parameter int  DATA_WIDTH   = 8,
  parameter int  ROUND_ROBIN  = 1,
  parameter int  PACKET_LOCK  = 0,
  localparam int SOURCE_WIDTH = source_width(NUM_INPUTS)
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]          in_last,
  input  logic [NUM_INPUTS-1:0]          in_valid,
  output logic [NUM_INPUTS-1:0]          in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_last,
  output logic [SOURCE_WIDTH-1:0]        out_source,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int BEAT_WIDTH = DATA_WIDTH + 1 + SOURCE_WIDTH;

  lock_state_e              lock_state;
  logic [SOURCE_WIDTH-1:0]  lock_index;
  logic [SOURCE_WIDTH-1:0]  pointer;
  logic [SOURCE_WIDTH-1:0]  next_pointer;
  logic [SOURCE_WIDTH-1:0]  scan_index;
  logic [SOURCE_WIDTH-1:0]  grant_index;
  logic [NUM_INPUTS-1:0]    grant;
  logic                     grant_found;
  logic                     accept_enable;
  logic                     can_accept;
  logic                     accept;
  logic [DATA_WIDTH-1:0]    accept_data;
  logic                     accept_last;
  logic [BEAT_WIDTH-1:0]    beat_in;
  logic [BEAT_WIDTH-1:0]    beat_out;

  // Grant: the locked channel if it is valid, otherwise the first valid
  // channel scanning up from the pointer (rotating) or from 0 (fixed).
  // NOTE: every variable gets a default at the top of the combinational block
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    grant_found = 1'b0;
    scan_index  = '0;
    if (PACKET_LOCK != 0 && lock_state == ARB_LOCKED) begin
      if (in_valid[lock_index]) begin
        grant[lock_index] = 1'b1;
        grant_index       = lock_index;
        grant_found       = 1'b1;
      end
    end else begin
      for (int k = 0; k < NUM_INPUTS; k++) begin
        scan_index = (ROUND_ROBIN != 0) ? SOURCE_WIDTH'((int'(pointer) + k) % NUM_INPUTS)
                                        : SOURCE_WIDTH'(k);
        if (!grant_found && in_valid[scan_index]) begin
          grant[scan_index] = 1'b1;
          grant_index       = scan_index;
          grant_found       = 1'b1;
        end
      end
    end
  end

  // Payload of the granted channel (grant is one-hot or zero).
  always_comb begin
    accept_data = '0;
    accept_last = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant[i]) begin
        accept_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        accept_last = in_last[i];
      end
    end
  end

  // accept_enable keeps in_ready low during reset and on the first edge after
  // release; can_accept comes from the skid stage and ignores out_ready.
  assign in_ready     = (accept_enable && can_accept) ? grant : '0;
  assign accept       = accept_enable && can_accept && grant_found;
  assign next_pointer = (grant_index == SOURCE_WIDTH'(NUM_INPUTS - 1)) ? '0
                                                                       : grant_index + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      accept_enable <= 1'b0;
      pointer       <= '0;
      lock_state    <= ARB_FREE;
      lock_index    <= '0;
    end else begin
      accept_enable <= 1'b1;
      if (accept) begin
        // With packet lock the rotation only advances once a packet completes.
        if (ROUND_ROBIN != 0 && (PACKET_LOCK == 0 || accept_last)) begin
          pointer <= next_pointer;
        end
        if (PACKET_LOCK != 0) begin
          if (accept_last) begin
            lock_state <= ARB_FREE;
          end else begin
            lock_state <= ARB_LOCKED;
            lock_index <= grant_index;
          end
        end
      end
    end
  end

  assign beat_in = {accept_last, grant_index, accept_data};

  skid_register #(
    .WIDTH(BEAT_WIDTH)
  ) u_skid_register (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_data  (beat_in),
    .in_valid (accept),
    .in_ready (can_accept),
    .out_data (beat_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign {out_last, out_source, out_data} = beat_out;

endmodule

// File: tb/tb_arbiter_n_to_1.sv
// Directed bench for arbiter_n_to_1 with three configurations:
//   rr : rotating priority, no packet lock
//   fx : fixed priority, no packet lock
//   pl : rotating priority with packet lock
module tb_arbiter_n_to_1;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  logic [N*DW-1:0] rr_in_data, fx_in_data, pl_in_data;
  logic [N-1:0]    rr_in_last, fx_in_last, pl_in_last;
  logic [N-1:0]    rr_in_valid, fx_in_valid, pl_in_valid;
  logic [N-1:0]    rr_in_ready, fx_in_ready, pl_in_ready;
  logic [DW-1:0]   rr_out_data, fx_out_data, pl_out_data;
  logic            rr_out_last, fx_out_last, pl_out_last;
  logic [SW-1:0]   rr_out_source, fx_out_source, pl_out_source;
  logic            rr_out_valid, fx_out_valid, pl_out_valid;
  logic            rr_out_ready, fx_out_ready, pl_out_ready;

  arbiter_n_to_1 #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .ROUND_ROBIN(1), .PACKET_LOCK(0)) u_rr (
    .clock(clock), .reset_n(reset_n), .in_data(rr_in_data), .in_last(rr_in_last),
    .in_valid(rr_in_valid), .in_ready(rr_in_ready), .out_data(rr_out_data),
    .out_last(rr_out_last), .out_source(rr_out_source), .out_valid(rr_out_valid),
    .out_ready(rr_out_ready));

  arbiter_n_to_1 #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .ROUND_ROBIN(0), .PACKET_LOCK(0)) u_fx (
    .clock(clock), .reset_n(reset_n), .in_data(fx_in_data), .in_last(fx_in_last),
    .in_valid(fx_in_valid), .in_ready(fx_in_ready), .out_data(fx_out_data),
    .out_last(fx_out_last), .out_source(fx_out_source), .out_valid(fx_out_valid),
    .out_ready(fx_out_ready));

  arbiter_n_to_1 #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .ROUND_ROBIN(1), .PACKET_LOCK(1)) u_pl (
    .clock(clock), .reset_n(reset_n), .in_data(pl_in_data), .in_last(pl_in_last),
    .in_valid(pl_in_valid), .in_ready(pl_in_ready), .out_data(pl_out_data),
    .out_last(pl_out_last), .out_source(pl_out_source), .out_valid(pl_out_valid),
    .out_ready(pl_out_ready));

  // Reset held with every channel requesting; nothing may be offered or
  // accepted, including on the first edge after release.
  task automatic test_reset();
    rr_in_valid = 4'b1111; fx_in_valid = 4'b1111; pl_in_valid = 4'b1111;
    repeat (3) @(negedge clock);
    compared++;
    if (rr_in_ready !== 4'b0000) begin mismatched++; $display("FAIL reset_rr_in_ready: got %b want 0000", rr_in_ready); end
    compared++;
    if (fx_in_ready !== 4'b0000) begin mismatched++; $display("FAIL reset_fx_in_ready: got %b want 0000", fx_in_ready); end
    compared++;
    if (pl_in_ready !== 4'b0000) begin mismatched++; $display("FAIL reset_pl_in_ready: got %b want 0000", pl_in_ready); end
    compared++;
    if (rr_out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", rr_out_valid); end
    compared++;
    if ({rr_out_last, rr_out_source, rr_out_data} !== 11'd0) begin
      mismatched++; $display("FAIL reset_out_fields: got last=%b src=%0d data=%h want all 0", rr_out_last, rr_out_source, rr_out_data);
    end
    fx_in_valid = 4'b0000;
    pl_in_valid = 4'b0000;
    reset_n = 1'b1;
    @(negedge clock);
    compared++;
    if (rr_out_valid !== 1'b0) begin mismatched++; $display("FAIL first_edge_no_accept: out_valid got %b want 0", rr_out_valid); end
    compared++;
    if (rr_in_ready !== 4'b0001) begin mismatched++; $display("FAIL first_ready_after_reset: got %b want 0001", rr_in_ready); end
  endtask

  // All channels valid, sink always ready: strict rotation at one beat per cycle.
  task automatic test_back_to_back();
    logic [SW-1:0] exp_src;
    logic [N-1:0]  exp_ready;
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      exp_src   = SW'(j % N);
      exp_ready = N'(1 << ((j + 1) % N));
      compared++;
      if (rr_out_valid !== 1'b1 || rr_out_source !== exp_src) begin
        mismatched++; $display("FAIL rr_rotation[%0d]: got valid=%b src=%0d want valid=1 src=%0d", j, rr_out_valid, rr_out_source, exp_src);
      end
      compared++;
      if (rr_out_data !== 8'hA0 + DW'(j % N)) begin
        mismatched++; $display("FAIL rr_rotation_data[%0d]: got %h want %h", j, rr_out_data, 8'hA0 + DW'(j % N));
      end
      compared++;
      if (rr_in_ready !== exp_ready) begin
        mismatched++; $display("FAIL rr_rotation_ready[%0d]: got %b want %b", j, rr_in_ready, exp_ready);
      end
    end
  endtask

  // Sparse requests 1010 with pointer at 0: rotation skips idle channels.
  task automatic test_rr_skip();
    logic [SW-1:0] exp_src [4];
    exp_src = '{2'd1, 2'd3, 2'd1, 2'd3};
    rr_in_valid = 4'b1010;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      compared++;
      if (rr_out_valid !== 1'b1 || rr_out_source !== exp_src[j]) begin
        mismatched++; $display("FAIL rr_skip[%0d]: got valid=%b src=%0d want valid=1 src=%0d", j, rr_out_valid, rr_out_source, exp_src[j]);
      end
    end
    rr_in_valid = 4'b0000;
    @(negedge clock);
    compared++;
    if (rr_out_valid !== 1'b0) begin mismatched++; $display("FAIL rr_idle: out_valid got %b want 0", rr_out_valid); end
  endtask

  // Fixed priority: channel 1 always beats channel 3.
  task automatic test_fixed_priority();
    fx_out_ready = 1'b1;
    fx_in_data[1*DW +: DW] = 8'hB1;
    fx_in_data[3*DW +: DW] = 8'hB3;
    fx_in_valid = 4'b1010;
    #1;
    compared++;
    if (fx_in_ready !== 4'b0010) begin mismatched++; $display("FAIL fx_first_ready: got %b want 0010", fx_in_ready); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      compared++;
      if (fx_out_valid !== 1'b1 || fx_out_source !== 2'd1 || fx_out_data !== 8'hB1) begin
        mismatched++; $display("FAIL fx_winner[%0d]: got valid=%b src=%0d data=%h want valid=1 src=1 data=b1", j, fx_out_valid, fx_out_source, fx_out_data);
      end
      compared++;
      if (fx_in_ready !== 4'b0010) begin
        mismatched++; $display("FAIL fx_ch3_starved[%0d]: in_ready got %b want 0010", j, fx_in_ready);
      end
    end
    fx_in_valid = 4'b0000;
  endtask

  // Sink stalls: output holds, skid takes one beat, ready drops, then drains in order.
  task automatic test_backpressure();
    rr_out_ready = 1'b0;
    rr_in_data[0 +: DW] = 8'h50;
    rr_in_valid = 4'b0001;
    #1;
    compared++;
    if (rr_in_ready !== 4'b0001) begin mismatched++; $display("FAIL bp_ready0: got %b want 0001", rr_in_ready); end
    @(negedge clock);
    compared++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 8'h50 || rr_in_ready !== 4'b0001) begin
      mismatched++; $display("FAIL bp_first: got valid=%b data=%h ready=%b want 1/50/0001", rr_out_valid, rr_out_data, rr_in_ready);
    end
    rr_in_data[0 +: DW] = 8'h51;
    @(negedge clock);
    compared++;
    if (rr_in_ready !== 4'b0000 || rr_out_data !== 8'h50) begin
      mismatched++; $display("FAIL bp_skid_full: got ready=%b data=%h want 0000/50", rr_in_ready, rr_out_data);
    end
    rr_in_data[0 +: DW] = 8'h52;
    @(negedge clock);
    compared++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 8'h50 || rr_in_ready !== 4'b0000) begin
      mismatched++; $display("FAIL bp_hold: got valid=%b data=%h ready=%b want 1/50/0000", rr_out_valid, rr_out_data, rr_in_ready);
    end
    rr_out_ready = 1'b1;
    @(negedge clock);
    compared++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 8'h51 || rr_in_ready !== 4'b0001) begin
      mismatched++; $display("FAIL bp_drain_skid: got valid=%b data=%h ready=%b want 1/51/0001", rr_out_valid, rr_out_data, rr_in_ready);
    end
    @(negedge clock);
    compared++;
    if (rr_out_valid !== 1'b1 || rr_out_data !== 8'h52) begin
      mismatched++; $display("FAIL bp_next_beat: got valid=%b data=%h want 1/52", rr_out_valid, rr_out_data);
    end
    rr_in_valid = 4'b0000;
    @(negedge clock);
    compared++;
    if (rr_out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_empty: out_valid got %b want 0", rr_out_valid); end
  endtask

  // Packet lock: per-cycle requests, last flags and hand-derived in_ready.
  typedef struct packed {
    logic [N-1:0] valid;
    logic [N-1:0] last;
    logic [N-1:0] ready;
  } pl_step_t;

  task automatic test_packet_lock();
    pl_step_t      steps [11];
    logic          exp_valid;
    logic          exp_last;
    logic [SW-1:0] exp_src;
    steps[0]  = '{4'b0010, 4'b0010, 4'b0010}; // ch1 single beat, pointer -> 2
    steps[1]  = '{4'b0101, 4'b0000, 4'b0100}; // ch2 beat 1 wins over ch0, lock
    steps[2]  = '{4'b0001, 4'b0000, 4'b0000}; // locked, ch2 idle: ch0 blocked
    steps[3]  = '{4'b0101, 4'b0000, 4'b0100}; // ch2 beat 2
    steps[4]  = '{4'b0101, 4'b0100, 4'b0100}; // ch2 last, pointer -> 3
    steps[5]  = '{4'b0001, 4'b0001, 4'b0001}; // ch0, pointer -> 1
    steps[6]  = '{4'b0101, 4'b0001, 4'b0100}; // ch2 from pointer 1, lock
    steps[7]  = '{4'b1101, 4'b0100, 4'b0100}; // ch2 last, ch3 must wait
    steps[8]  = '{4'b1001, 4'b1001, 4'b1000}; // pointer 3 picks ch3 over ch0
    steps[9]  = '{4'b0001, 4'b0001, 4'b0001}; // ch0
    steps[10] = '{4'b0000, 4'b0000, 4'b0000};
    pl_out_ready = 1'b1;
    for (int i = 0; i < N; i++) pl_in_data[i*DW +: DW] = 8'hC0 + DW'(i);
    for (int c = 0; c < 11; c++) begin
      pl_in_valid = steps[c].valid;
      pl_in_last  = steps[c].last;
      #1;
      compared++;
      if (pl_in_ready !== steps[c].ready) begin
        mismatched++; $display("FAIL pl_ready[%0d]: got %b want %b", c, pl_in_ready, steps[c].ready);
      end
      @(negedge clock);
      exp_valid = (steps[c].ready != '0);
      exp_last  = |(steps[c].ready & steps[c].last);
      exp_src   = '0;
      for (int i = 0; i < N; i++) if (steps[c].ready[i]) exp_src = SW'(i);
      compared++;
      if (pl_out_valid !== exp_valid) begin
        mismatched++; $display("FAIL pl_valid[%0d]: got %b want %b", c, pl_out_valid, exp_valid);
      end
      if (exp_valid) begin
        compared++;
        if (pl_out_source !== exp_src || pl_out_last !== exp_last || pl_out_data !== 8'hC0 + DW'(exp_src)) begin
          mismatched++; $display("FAIL pl_beat[%0d]: got src=%0d last=%b data=%h want src=%0d last=%b data=%h",
                                 c, pl_out_source, pl_out_last, pl_out_data, exp_src, exp_last, 8'hC0 + DW'(exp_src));
        end
      end
    end
  endtask

  // Random valid/ready with a per-channel sequence scoreboard on rr.
  task automatic test_random();
    logic [5:0]   send_seq [N];
    logic [5:0]   recv_seq [N];
    int           wait_cnt [N];
    int           sent;
    int           recv;
    logic [N-1:0] acc;
    sent = 0;
    recv = 0;
    for (int i = 0; i < N; i++) begin send_seq[i] = '0; recv_seq[i] = '0; wait_cnt[i] = 0; end
    rr_in_valid = '0;
    rr_in_last  = '0;
    for (int cyc = 0; cyc < 10100; cyc++) begin
      if (cyc < 10000) begin
        for (int i = 0; i < N; i++) begin
          if (!rr_in_valid[i] && $urandom_range(1, 0) == 1) begin
            rr_in_valid[i] = 1'b1;
            rr_in_data[i*DW +: DW] = {SW'(i), send_seq[i]};
          end
        end
        rr_out_ready = ($urandom_range(3, 0) != 0);
      end else begin
        rr_out_ready = 1'b1;
      end
      #1;
      compared++;
      if ($countones(rr_in_ready) > 1) begin
        mismatched++; $display("FAIL rnd_onehot[%0d]: in_ready got %b want at most one bit", cyc, rr_in_ready);
      end
      acc = rr_in_valid & rr_in_ready;
      if (rr_out_valid && rr_out_ready) begin
        compared++;
        if (rr_out_data !== {rr_out_source, recv_seq[rr_out_source]}) begin
          mismatched++; $display("FAIL rnd_order[%0d]: got %h want %h", cyc, rr_out_data, {rr_out_source, recv_seq[rr_out_source]});
        end
        recv_seq[rr_out_source] = recv_seq[rr_out_source] + 1'b1;
        recv++;
      end
      if (acc != '0) begin
        for (int i = 0; i < N; i++) begin
          if (acc[i]) begin
            wait_cnt[i] = 0;
          end else if (rr_in_valid[i]) begin
            wait_cnt[i]++;
            // Rotation lets at most the other N-1 channels go first.
            compared++;
            if (wait_cnt[i] > N - 1) begin
              mismatched++; $display("FAIL rnd_fairness[%0d]: ch%0d waited %0d grants want <= %0d", cyc, i, wait_cnt[i], N - 1);
            end
          end
        end
      end
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          rr_in_valid[i] = 1'b0;
          send_seq[i] = send_seq[i] + 1'b1;
          sent++;
        end
      end
    end
    compared++;
    if (sent !== recv || sent < 1000) begin
      mismatched++; $display("FAIL rnd_count: delivered %0d of %0d accepted beats (need equal and >= 1000)", recv, sent);
    end
  endtask

  initial begin
    rr_in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    fx_in_data  = '0;
    pl_in_data  = '0;
    rr_in_last  = '0; fx_in_last  = '0; pl_in_last  = '0;
    rr_in_valid = '0; fx_in_valid = '0; pl_in_valid = '0;
    rr_out_ready = 1'b1; fx_out_ready = 1'b1; pl_out_ready = 1'b1;
    test_reset();
    test_back_to_back();
    test_rr_skip();
    test_fixed_priority();
    test_backpressure();
    test_packet_lock();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
